// File: rtl/adc_capture_gate.sv
// Trigger-delayed gate for an AXI4-Stream ADC feed: a capture_i rising edge opens
// the gate after delay_i cycles for length_i cycles, then pulses done_o.
module adc_capture_gate #(
    parameter int unsigned DWIDTH  = 128,
    parameter int unsigned CNTBITS = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               capture_i,
    input  logic [CNTBITS-1:0] delay_i,
    input  logic [CNTBITS-1:0] length_i,
    input  logic [DWIDTH-1:0]  adc_tdata,
    input  logic               adc_tvalid,
    output logic               adc_tready,
    output logic [DWIDTH-1:0]  gate_tdata,
    output logic               gate_tvalid,
    output logic               gate_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {StIdle, StDelay, StGate, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic [CNTBITS-1:0] len_q, len_d;
    logic [1:0]         cap_q;
    logic               armed_q;
    logic               trigger;

    // armed_q requires capture_i to be seen low after reset, so a level held
    // high through reset release is not mistaken for a rising edge.
    assign trigger = cap_q[0] & ~cap_q[1] & armed_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cap_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cap_q   <= {cap_q[0], capture_i};
            armed_q <= armed_q | ~capture_i;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Counters are loaded with N-1 so that an N-cycle phase ends when they hit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    len_d = length_i;
                    if (delay_i != '0) begin
                        state_d = StDelay;
                        cnt_d   = delay_i - CNTBITS'(1);
                    end else if (length_i != '0) begin
                        state_d = StGate;
                        cnt_d   = length_i - CNTBITS'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == '0) begin
                    if (len_q != '0) begin
                        state_d = StGate;
                        cnt_d   = len_q - CNTBITS'(1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - CNTBITS'(1);
                end
            end
            StGate: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNTBITS'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign gate_o     = (state_q == StGate);
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign adc_tready = 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            gate_tdata  <= '0;
            gate_tvalid <= 1'b0;
        end else begin
            gate_tdata  <= (gate_o && adc_tvalid) ? adc_tdata : '0;
            gate_tvalid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate: table of delay/length vectors plus hand
// sequences for reset behaviour, retrigger and mid-capture parameter changes.
module tb_adc_capture_gate;

    localparam int DW = 128;
    localparam int CB = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          capture_i;
    logic [CB-1:0] delay_i;
    logic [CB-1:0] length_i;
    logic [DW-1:0] adc_tdata;
    logic          adc_tvalid;
    logic          adc_tready;
    logic [DW-1:0] gate_tdata;
    logic          gate_tvalid;
    logic          gate_o;
    logic          busy_o;
    logic          done_o;

    adc_capture_gate #(.DWIDTH(DW), .CNTBITS(CB)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .capture_i  (capture_i),
        .delay_i    (delay_i),
        .length_i   (length_i),
        .adc_tdata  (adc_tdata),
        .adc_tvalid (adc_tvalid),
        .adc_tready (adc_tready),
        .gate_tdata (gate_tdata),
        .gate_tvalid(gate_tvalid),
        .gate_o     (gate_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int d;
        int l;
        int inv_lo;
        int inv_hi;
        int gate_cnt;
        int done_off;
        int nz_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_data(input bit valid);
        adc_tdata  = {4{cyc + 32'h100}};
        adc_tvalid = valid;
    endtask

    // One capture; expected per-cycle outputs come from the trigger-relative window.
    task automatic run_capture(input int idx, input vec_t v, input bit disturb);
        int n;
        int gates = 0;
        int dones = 0;
        int nz = 0;
        int done_at = -1;
        logic prev_g = 1'b0;
        logic prev_v;
        logic valid;
        logic g_exp;
        logic [DW-1:0] prev_dat;
        logic [DW-1:0] td_exp;
        n = v.d + v.l + (disturb ? 12 : 3);
        @(negedge aclk);
        delay_i   = CB'(v.d);
        length_i  = CB'(v.l);
        capture_i = 1'b1;
        drive_data(1'b1);
        prev_v   = 1'b1;
        prev_dat = adc_tdata;
        for (int k = 0; k <= n; k++) begin
            @(posedge aclk);
            @(negedge aclk);
            if (k == 0) capture_i = 1'b0;
            if (disturb) begin
                if (k == 2) delay_i = 16'd100;
                if (k == 5) capture_i = 1'b1;
                if (k == 6) capture_i = 1'b0;
            end
            g_exp  = (k >= 1 + v.d) && (k <= v.d + v.l);
            td_exp = (prev_g && prev_v) ? prev_dat : '0;
            check($sformatf("v%0d k=%0d gate_o", idx, k), DW'(gate_o), DW'(g_exp));
            check($sformatf("v%0d k=%0d done_o", idx, k), DW'(done_o), DW'(k == 1 + v.d + v.l));
            check($sformatf("v%0d k=%0d busy_o", idx, k), DW'(busy_o),
                  DW'((k >= 1) && (k <= 1 + v.d + v.l)));
            check($sformatf("v%0d k=%0d gate_tdata", idx, k), gate_tdata, td_exp);
            gates += int'(gate_o);
            dones += int'(done_o);
            if (done_o && done_at < 0) done_at = k;
            if (gate_tdata != '0) nz++;
            prev_g = g_exp;
            valid  = !((k >= v.inv_lo) && (k <= v.inv_hi));
            drive_data(valid);
            prev_v   = valid;
            prev_dat = adc_tdata;
        end
        check($sformatf("v%0d gate width", idx), DW'(gates), DW'(v.gate_cnt));
        check($sformatf("v%0d done count", idx), DW'(dones), DW'(1));
        check($sformatf("v%0d done offset", idx), DW'(done_at), DW'(v.done_off));
        check($sformatf("v%0d nonzero words", idx), DW'(nz), DW'(v.nz_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // d, l, inv_lo, inv_hi, gate_cnt, done_off, nz_cnt
        vecs[0] = '{3, 4, -1, -2, 4, 8, 4};
        vecs[1] = '{0, 1, -1, -2, 1, 2, 1};
        vecs[2] = '{5, 0, -1, -2, 0, 6, 0};
        vecs[3] = '{0, 0, -1, -2, 0, 1, 0};
        vecs[4] = '{2, 6,  4,  5, 6, 9, 4};
        vecs[5] = '{1, 2, -1, -2, 2, 4, 2};

        aresetn   = 1'b0;
        capture_i = 1'b1;
        delay_i   = '0;
        length_i  = '0;
        drive_data(1'b1);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst gate_o", DW'(gate_o), '0);
        check("rst busy_o", DW'(busy_o), '0);
        check("rst done_o", DW'(done_o), '0);
        check("rst gate_tdata", gate_tdata, '0);
        check("rst gate_tvalid", DW'(gate_tvalid), '0);
        check("rst adc_tready", DW'(adc_tready), DW'(1));

        // Release with capture_i still high: no capture may start.
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            check($sformatf("held-high busy_o c%0d", i), DW'(busy_o), '0);
            check($sformatf("held-high done_o c%0d", i), DW'(done_o), '0);
        end
        check("gate_tvalid after release", DW'(gate_tvalid), DW'(1));
        capture_i = 1'b0;
        repeat (2) @(negedge aclk);

        for (int i = 0; i < 6; i++) run_capture(i, vecs[i], 1'b0);

        // Retrigger during GATE and delay_i change mid-capture are ignored.
        run_capture(6, vecs[0], 1'b1);

        // Reset during GATE with capture_i held high.
        @(negedge aclk);
        delay_i   = 16'd1;
        length_i  = 16'd5;
        capture_i = 1'b1;
        drive_data(1'b1);
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("pre-abort gate_o", DW'(gate_o), DW'(1));
        aresetn = 1'b0;
        #1;
        check("abort gate_o", DW'(gate_o), '0);
        check("abort busy_o", DW'(busy_o), '0);
        check("abort done_o", DW'(done_o), '0);
        check("abort gate_tdata", gate_tdata, '0);
        check("abort gate_tvalid", DW'(gate_tvalid), '0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check($sformatf("post-abort busy_o c%0d", i), DW'(busy_o), '0);
            check($sformatf("post-abort done_o c%0d", i), DW'(done_o), '0);
        end
        capture_i = 1'b0;
        repeat (2) @(negedge aclk);
        capture_i = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        check("re-armed busy_o", DW'(busy_o), DW'(1));
        capture_i = 1'b0;
        repeat (12) @(negedge aclk);
        check("re-armed idle busy_o", DW'(busy_o), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
